// File: rtl/pmu_quota_regulator.sv
// -----------------------------------------------------------------------------
// pmu_quota_regulator
//
// Per-core memory-bandwidth budget regulator. It reacts to the quota-exceeded
// interrupt from the PMU quota monitor by holding the core with a stall
// request/acknowledge handshake until the current regulation period ends. At
// every period boundary it pulses a soft reset into the quota monitor, which
// replenishes the budget, and it releases the stall in the same cycle.
// Saturating statistics are kept for software.
//
// Ports
//   clk_i           clock
//   rst_i           asynchronous, active-high reset
//   enable_i        regulation enable; low forces IDLE
//   period_i        regulation period in clk_i cycles (values below 2 act as 2)
//   intr_quota_i    quota-exceeded level from the monitor (sticky until soft reset)
//   stall_ack_i     core acknowledges it is held
//   clr_stats_i     synchronous clear of both statistics counters
//   stall_req_o     stall request to the core (registered)
//   quota_rst_o     one-cycle soft-reset pulse to the quota monitor (registered)
//   throttle_cnt_o  number of throttle episodes, saturating
//   stall_cycles_o  cycles spent in STALLED, saturating
//
// State table
//   state       | meaning
//   ------------+--------------------------------------------------------------
//   IDLE        | regulation off, no stall, counter parked at 0
//   REPLENISH   | one cycle: soft-reset pulse, load period, release the stall
//   MONITOR     | budget available, watching for the quota interrupt
//   STALL_REQ   | stall requested, waiting for the core's acknowledge
//   STALLED     | core held until the period ends
// -----------------------------------------------------------------------------
module pmu_quota_regulator #(
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [REG_WIDTH-1:0] period_i,
  input  logic                 intr_quota_i,
  input  logic                 stall_ack_i,
  input  logic                 clr_stats_i,
  output logic                 stall_req_o,
  output logic                 quota_rst_o,
  output logic [REG_WIDTH-1:0] throttle_cnt_o,
  output logic [REG_WIDTH-1:0] stall_cycles_o
);

  localparam logic [REG_WIDTH-1:0] PERIOD_MIN = REG_WIDTH'(2);
  localparam logic [REG_WIDTH-1:0] ONE        = REG_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REPLENISH = 3'd1,
    S_MONITOR   = 3'd2,
    S_STALL_REQ = 3'd3,
    S_STALLED   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [REG_WIDTH-1:0] period_q, period_d;
  logic [REG_WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic [REG_WIDTH-1:0] throttle_q, throttle_d;
  logic [REG_WIDTH-1:0] stall_cyc_q, stall_cyc_d;
  logic                 stall_req_q, quota_rst_q;

  logic [REG_WIDTH-1:0] period_sat;
  logic [REG_WIDTH-1:0] period_last;
  logic                 period_end;
  logic                 blanking;
  logic                 throttle_inc;
  logic                 stall_inc;

  assign period_sat  = (period_i < PERIOD_MIN) ? PERIOD_MIN : period_i;
  // period_q is never below 2, so this cannot underflow.
  assign period_last = period_q - ONE;
  assign period_end  = (period_cnt_q == period_last);
  // The counter is loaded with 1 in REPLENISH, so a count of 1 in MONITOR
  // marks the first cycle after the soft reset, while the monitor's
  // interrupt may still be clearing.
  assign blanking    = (period_cnt_q == ONE);
  assign stall_inc   = (state_q == S_STALLED);

  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    period_cnt_d = period_cnt_q;
    throttle_inc = 1'b0;

    case (state_q)
      S_IDLE: begin
        period_cnt_d = '0;
        if (enable_i) state_d = S_REPLENISH;
      end
      S_REPLENISH: begin
        period_d     = period_sat;
        period_cnt_d = ONE;
        state_d      = S_MONITOR;
      end
      S_MONITOR: begin
        period_cnt_d = period_cnt_q + ONE;
        if (period_end) begin
          state_d = S_REPLENISH;
        end else if (intr_quota_i && !blanking) begin
          state_d      = S_STALL_REQ;
          throttle_inc = 1'b1;
        end
      end
      S_STALL_REQ: begin
        period_cnt_d = period_cnt_q + ONE;
        if (period_end)       state_d = S_REPLENISH;
        else if (stall_ack_i) state_d = S_STALLED;
      end
      S_STALLED: begin
        period_cnt_d = period_cnt_q + ONE;
        if (period_end) state_d = S_REPLENISH;
      end
      default: begin
        state_d      = S_IDLE;
        period_cnt_d = '0;
      end
    endcase

    // Disable overrides everything, including a pending period end, so no
    // soft-reset pulse is produced on the way out.
    if (!enable_i) begin
      state_d      = S_IDLE;
      period_cnt_d = '0;
      throttle_inc = 1'b0;
    end
  end

  always_comb begin
    throttle_d = throttle_q;
    if (clr_stats_i)                        throttle_d = '0;
    else if (throttle_inc && throttle_q != '1) throttle_d = throttle_q + ONE;
  end

  always_comb begin
    stall_cyc_d = stall_cyc_q;
    if (clr_stats_i)                        stall_cyc_d = '0;
    else if (stall_inc && stall_cyc_q != '1) stall_cyc_d = stall_cyc_q + ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      period_q     <= PERIOD_MIN;
      period_cnt_q <= '0;
      throttle_q   <= '0;
      stall_cyc_q  <= '0;
      stall_req_q  <= 1'b0;
      quota_rst_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      period_cnt_q <= period_cnt_d;
      throttle_q   <= throttle_d;
      stall_cyc_q  <= stall_cyc_d;
      // Outputs are decoded from the next state so they line up with state_q.
      stall_req_q  <= (state_d == S_STALL_REQ) || (state_d == S_STALLED);
      quota_rst_q  <= (state_d == S_REPLENISH);
    end
  end

  assign stall_req_o    = stall_req_q;
  assign quota_rst_o    = quota_rst_q;
  assign throttle_cnt_o = throttle_q;
  assign stall_cycles_o = stall_cyc_q;

endmodule

// File: doc/pmu_quota_regulator.md
Name: pmu_quota_regulator

Overview:
- Responder to the per-core quota interrupt. Sits between the PMU quota monitor and the core's pipeline-hold logic.
- On a quota interrupt it requests a core stall (req/ack handshake) and holds it until the current regulation period expires.
- At each period boundary it pulses a soft reset into the quota monitor to replenish the budget and releases the stall (MemGuard-style budget regulation).
- Also keeps saturating statistics for software.

Parameters:
- REG_WIDTH, 32, width of the period register and statistics counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  regulation enable; 0 forces IDLE.
- period_i  in  REG_WIDTH  regulation period in clk_i cycles. Values <2 are treated as 2.
- intr_quota_i  in  1  quota-exceeded interrupt from the quota monitor (level, sticky until soft reset).
- stall_ack_i  in  1  core acknowledges that it is held.
- clr_stats_i  in  1  synchronous clear of the statistics counters.
- stall_req_o  out  1  stall request to the core.
- quota_rst_o  out  1  one-cycle soft-reset pulse to the quota monitor (active-high).
- throttle_cnt_o  out  REG_WIDTH  number of throttle episodes, saturating.
- stall_cycles_o  out  REG_WIDTH  cycles spent in STALLED, saturating.

Behaviour:
- Reset: state=IDLE; period_cnt=0; period_q=2; all outputs 0. Reset is asynchronous and may assert mid-operation: the stall is dropped immediately and no quota_rst pulse is emitted.
- All outputs are registered: stall_req_o=(state∈{STALL_REQ,STALLED}); quota_rst_o=(state==REPLENISH).
- FSM states: IDLE, REPLENISH, MONITOR, STALL_REQ, STALLED.
- Priority in any non-IDLE state: enable_i=0 > period end > local conditions.
- enable_i=0 in any state → IDLE next cycle. No quota_rst pulse; stall released.
- IDLE: enable_i=1 → REPLENISH.
- REPLENISH (exactly 1 cycle):
  - period_q ← max(period_i,2); period_cnt ← 1.
  - → MONITOR.
  - period_i changes take effect only at REPLENISH.
- period_cnt increments by 1 every cycle in MONITOR, STALL_REQ and STALLED.
- Period end = (period_cnt == period_q-1) in MONITOR, STALL_REQ or STALLED → REPLENISH next cycle. quota_rst_o therefore pulses exactly every period_q cycles.
- MONITOR:
  - Period end → REPLENISH. This wins over a simultaneous intr_quota_i: no stall, no throttle count.
  - Else intr_quota_i=1 → STALL_REQ, and throttle_cnt increments.
  - intr_quota_i is ignored in the first MONITOR cycle after REPLENISH (blanking cycle while the monitor clears).
- STALL_REQ:
  - Period end → REPLENISH (request withdrawn, no ack needed).
  - Else stall_ack_i=1 → STALLED.
- STALLED:
  - stall_cycles increments every cycle in this state.
  - Period end → REPLENISH.
  - stall_ack_i is not re-checked here.
- stall_ack_i is ignored outside STALL_REQ.
- intr_quota_i is ignored in STALL_REQ, STALLED, REPLENISH and IDLE.
- Latency:
  - intr_quota_i sampled high in MONITOR at edge t → stall_req_o=1 after edge t (visible in cycle t+1).
  - Release occurs in the REPLENISH cycle, simultaneously with quota_rst_o=1.
- Statistics:
  - Both counters saturate at all-ones with no wrap.
  - clr_stats_i zeroes both counters. If a clear and an increment fall in the same cycle, the clear wins.
  - The counters are not cleared by enable_i.
- Arithmetic: period_cnt is REG_WIDTH wide. The comparison uses period_q-1 computed in REG_WIDTH with period_q≥2, so it cannot underflow.

Test Plan:
- Free run: enable_i=1, period_i=10, intr_quota_i=0.
  - Expect quota_rst_o pulses at cycles 1, 11, 21 after enable.
  - Expect stall_req_o=0 throughout and throttle_cnt_o=0.
- Throttle: period_i=20; intr_quota_i=1 at cycle 5 after REPLENISH; stall_ack_i returned 2 cycles after the request.
  - Expect stall_req_o high from cycle 6 through cycle 19, low at REPLENISH (cycle 20), with quota_rst_o=1 at cycle 20.
  - Expect throttle_cnt_o=1 and stall_cycles_o=11.
- Boundary collision: intr_quota_i rises exactly in the period-end MONITOR cycle.
  - Expect REPLENISH next, no stall_req_o, throttle_cnt_o unchanged.
  - Also: intr held high through REPLENISH → ignored during the blanking cycle, stall requested only if still high on the following cycle.
- Min period / late change: period_i=0.
  - Expect quota_rst_o every 2 cycles.
  - Change period_i to 5 mid-period → new spacing starts only after the next pulse.
- Abort paths:
  - enable_i=0 during STALLED → stall_req_o=0 next cycle, no quota_rst_o pulse, state IDLE.
  - Async rst_i mid-STALL_REQ → all outputs 0 immediately.
- Saturation: force throttle_cnt_o to all-ones (REG_WIDTH=4 build, 16 episodes) → holds at 15. Assert clr_stats_i in the same cycle as an increment → 0.
